key_event_decoder: RTL and testbench
====================================

// Module: key_event_decoder
// PURPOSE
// Decodes the multi-slot USB HID keycode word from the MicroBlaze/USB host into per-key held state,
// one-cycle press/release/auto-repeat pulses and a per-frame event snapshot stable for a whole frame.
// Sits between the USB keycode register and game logic (player/keeper control, color_mapper).
// Generalises single-slot keycode compares to NUM_SLOTS rollover slots, NUM_KEYS watched keys and auto-repeat.
// PARAMETERS
// NUM_SLOTS     4                       8-bit keycode slots in keycode word (slot0 = bits[7:0])
// NUM_KEYS      6                       watched keys
// KEY_CODES     48'h2C_28_07_16_04_1A   packed HID codes, key k = bits[8k+7:8k]; 8'h00 disables key k
// REPEAT_DELAY  20                      frames held before first repeat (>=1)
// REPEAT_RATE   4                       frames between later repeats (1..REPEAT_DELAY)
// PORTS
// clk_25MHz    in   1            pixel clock, all logic on rising edge
// reset_al     in   1            async active-low reset
// vsync        in   1            VGA vsync, same clock domain; rising edge = frame boundary
// keycode      in   NUM_SLOTS*8  raw HID keycode slots
// repeat_en    in   1            1 = auto-repeat enabled
// key_held     out  NUM_KEYS     key k currently down
// key_press    out  NUM_KEYS     1-cycle pulse on press
// key_release  out  NUM_KEYS     1-cycle pulse on release
// key_repeat   out  NUM_KEYS     1-cycle auto-repeat pulse, coincident with frame_tick
// key_frame    out  NUM_KEYS     presses/repeats from previous frame, stable for one frame
// frame_tick   out  1            1-cycle pulse, one cycle after vsync rising edge
// BEHAVIOUR
// - Reset: all outputs 0; keycode_q=0; held_r=0; pending=0; repeat counters=0; vsync_q=1
//   (vsync_q=1: no spurious frame_tick if vsync is high at reset release).
// - Cycle 1: keycode_q <= keycode. match[k] = KEY_CODES[k]!=0 && any slot of keycode_q == KEY_CODES[k].
// - Rollover: if any slot of keycode_q == 8'h01 (ErrorRollOver), match is ignored and held_r holds.
// - Cycle 2: held_r <= match; key_press <= match&~held_r; key_release <= ~match&held_r.
//   key_held = held_r. Latency keycode change -> key_held/key_press = 2 clocks.
// - Duplicate code in two slots = one press. Press+release within 1 cycle gives no event (min 2-cycle hold).
// - frame_tick <= vsync & ~vsync_q; vsync_q <= vsync.
// - pending[k] set by key_press[k] or key_repeat[k], cleared on frame_tick.
//   On frame_tick: key_frame <= pending | key_press | key_repeat; pending <= 0.
//   Press in the frame_tick cycle goes into the new snapshot, not into pending.
// - Repeat counter per key, width $clog2(REPEAT_DELAY+1):
//   * key_press or ~held_r or ~repeat_en -> counter = 0 (highest priority)
//   * on frame_tick while held_r && repeat_en: counter+1; on reaching REPEAT_DELAY:
//     key_repeat pulses that cycle, counter <= REPEAT_DELAY-REPEAT_RATE.
//   * Counter never exceeds REPEAT_DELAY (no wrap).
// - repeat_en dropping mid-hold: counter cleared, no repeat pulse. Re-enabling restarts the full delay.
// - Async reset mid-frame or mid-hold: all state cleared immediately. A key still down after reset
//   yields a fresh key_press 2 clocks after release of reset.
// TESTING
// 1 reset: reset_al=0, vsync=1, keycode=32'h1A -> all outputs 0; after release, no frame_tick until vsync rises again.
// 2 keycode 32'h0000_0028 from cycle t -> key_press[4]=1 at t+2 for exactly 1 cycle; key_held[4]=1 from t+2;
//   keycode->0 -> key_release[4] pulse 2 cycles later.
// 3 multi-slot keycode=32'h1A_04_00_1A -> key_press[0], key_press[1] same cycle, single pulse each;
//   then keycode=32'h01010101 -> key_held stays 6'b000011, no pulses.
// 4 press 0x2C mid-frame N -> key_frame[5]=1 from frame_tick N+1 until frame_tick N+2;
//   press coincident with frame_tick -> key_frame[5] set at that tick.
// 5 repeat_en=1, hold 0x07 for 32 frames -> key_repeat[3] on ticks 20,24,28,32 after press;
//   repeat_en=0 at tick 22 -> no repeat at 24.
// 6 assert reset_al low while key 0x16 held and counter=10 -> outputs 0 at once; after release,
//   key_press[2] 2 clocks later; first repeat 20 frames after that.

Source files
------------

// File: rtl/key_event_decoder.sv
// key_event_decoder
// Turns the multi-slot USB HID keycode word into per-key held state,
// one-cycle press/release pulses, frame-aligned auto-repeat pulses and a
// per-frame snapshot of presses/repeats that game logic can read at leisure.
// All logic runs on the 25 MHz pixel clock; vsync is already in this domain.

module key_event_decoder #(
    parameter int                      NUM_SLOTS    = 4,
    parameter int                      NUM_KEYS     = 6,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES    = 48'h2C_28_07_16_04_1A,
    parameter int                      REPEAT_DELAY = 20,
    parameter int                      REPEAT_RATE  = 4
) (
    input  logic                   clk_25MHz,
    input  logic                   reset_al,
    input  logic                   vsync,
    input  logic [NUM_SLOTS*8-1:0] keycode,
    input  logic                   repeat_en,
    output logic [NUM_KEYS-1:0]    key_held,
    output logic [NUM_KEYS-1:0]    key_press,
    output logic [NUM_KEYS-1:0]    key_release,
    output logic [NUM_KEYS-1:0]    key_repeat,
    output logic [NUM_KEYS-1:0]    key_frame,
    output logic                   frame_tick
);

    localparam int              CNT_W         = $clog2(REPEAT_DELAY + 1);
    // Counter value that, incremented by one more frame, reaches REPEAT_DELAY.
    localparam logic [CNT_W-1:0] LAST_STEP    = CNT_W'(REPEAT_DELAY - 1);
    // Reload so the next repeat lands REPEAT_RATE frames later.
    localparam logic [CNT_W-1:0] RELOAD       = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [7:0]       ROLLOVER_CODE = 8'h01;

    logic [NUM_SLOTS*8-1:0]           keycode_q;
    logic [NUM_KEYS-1:0]              held_q;
    logic [NUM_KEYS-1:0]              press_q;
    logic [NUM_KEYS-1:0]              release_q;
    logic                             vsync_q;
    logic                             tick_q;
    logic [NUM_KEYS-1:0]              pending_q, pending_d;
    logic [NUM_KEYS-1:0]              frame_q, frame_d;
    logic [NUM_KEYS-1:0][CNT_W-1:0]   cnt_q, cnt_d;

    logic                             rollover;
    logic [NUM_KEYS-1:0]              raw_match;
    logic [NUM_KEYS-1:0]              match;
    logic [NUM_KEYS-1:0]              repeat_now;

    // Decode the registered keycode word into a per-key "is down" vector.
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rollover  = 1'b0;
        raw_match = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (keycode_q[8*s +: 8] == ROLLOVER_CODE) begin
                rollover = 1'b1;
            end
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (KEY_CODES[8*k +: 8] != 8'h00 &&
                    keycode_q[8*s +: 8] == KEY_CODES[8*k +: 8]) begin
                    raw_match[k] = 1'b1;
                end
            end
        end
        // ErrorRollOver reports garbage in every slot: freeze the held state.
        match = rollover ? held_q : raw_match;
    end

    // Input capture, held state, edge pulses and vsync edge detection.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_25MHz or negedge reset_al) begin
        if (!reset_al) begin
            keycode_q <= '0;
            held_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            vsync_q   <= 1'b1;   // no spurious tick if vsync is high at release
            tick_q    <= 1'b0;
        end else begin
            keycode_q <= keycode;
            held_q    <= match;
            press_q   <= match & ~held_q;
            release_q <= ~match & held_q;
            vsync_q   <= vsync;
            tick_q    <= vsync & ~vsync_q;
        end
    end

    // Per-key auto-repeat counters; repeat pulses only in a frame_tick cycle.
    always_comb begin
        cnt_d      = cnt_q;
        repeat_now = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (press_q[k] || !held_q[k] || !repeat_en) begin
                cnt_d[k] = '0;
            end else if (tick_q) begin
                if (cnt_q[k] == LAST_STEP) begin
                    repeat_now[k] = 1'b1;
                    cnt_d[k]      = RELOAD;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_ONE;
                end
            end
        end
    end

    // Collect presses/repeats during a frame and publish them at the tick.
    always_comb begin
        if (tick_q) begin
            frame_d   = pending_q | press_q | repeat_now;
            pending_d = '0;
        end else begin
            frame_d   = frame_q;
            pending_d = pending_q | press_q | repeat_now;
        end
    end

    // Frame snapshot and repeat counter registers.
    always_ff @(posedge clk_25MHz or negedge reset_al) begin
        if (!reset_al) begin
            pending_q <= '0;
            frame_q   <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            frame_q   <= frame_d;
            cnt_q     <= cnt_d;
        end
    end

    assign key_held    = held_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_repeat  = repeat_now;
    assign key_frame   = frame_q;
    assign frame_tick  = tick_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed scenarios with
// expected values taken from the key behaviour, plus a randomized run
// compared cycle by cycle against a set-based reference model.

module tb_key_event_decoder;

    localparam int          NUM_SLOTS    = 4;
    localparam int          NUM_KEYS     = 6;
    localparam logic [47:0] KEY_CODES    = 48'h2C_28_07_16_04_1A;
    localparam int          REPEAT_DELAY = 20;
    localparam int          REPEAT_RATE  = 4;

    logic        clk_25MHz = 1'b0;
    logic        reset_al;
    logic        vsync;
    logic [31:0] keycode;
    logic        repeat_en;
    logic [5:0]  key_held, key_press, key_release, key_repeat, key_frame;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    key_event_decoder #(
        .NUM_SLOTS    (NUM_SLOTS),
        .NUM_KEYS     (NUM_KEYS),
        .KEY_CODES    (KEY_CODES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) dut (
        .clk_25MHz   (clk_25MHz),
        .reset_al    (reset_al),
        .vsync       (vsync),
        .keycode     (keycode),
        .repeat_en   (repeat_en),
        .key_held    (key_held),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .key_frame   (key_frame),
        .frame_tick  (frame_tick)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    // ---------------- reference model ----------------
    // Keys are matched by looking codes up in the set of codes present in
    // the word; auto-repeat is "n-th qualifying frame of the hold, where
    // n = DELAY, DELAY+RATE, DELAY+2*RATE, ...".
    logic [31:0] m_kc;
    logic [5:0]  m_held, m_press, m_release, m_pending, m_frame;
    logic        m_vs_prev, m_tick;
    int          m_ticks [NUM_KEYS];
    logic [5:0]  m_match_now, m_rep_now;

    function automatic logic [5:0] model_match(input logic [31:0] kc, input logic [5:0] held);
        logic [255:0] present;
        logic [47:0]  codes;
        logic [7:0]   code;
        logic [5:0]   m;
        present = '0;
        codes   = KEY_CODES;
        for (int s = 0; s < NUM_SLOTS; s++) present[kc[8*s +: 8]] = 1'b1;
        if (present[1]) return held;
        m = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            code = codes[8*k +: 8];
            m[k] = (code != 8'h00) && present[code];
        end
        return m;
    endfunction

    assign m_match_now = model_match(m_kc, m_held);

    always_comb begin
        m_rep_now = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (m_tick && m_held[k] && repeat_en && !m_press[k] &&
                (m_ticks[k] + 1 >= REPEAT_DELAY) &&
                ((m_ticks[k] + 1 - REPEAT_DELAY) % REPEAT_RATE == 0))
                m_rep_now[k] = 1'b1;
        end
    end

    always @(posedge clk_25MHz or negedge reset_al) begin
        if (!reset_al) begin
            m_kc <= '0; m_held <= '0; m_press <= '0; m_release <= '0;
            m_pending <= '0; m_frame <= '0; m_vs_prev <= 1'b1; m_tick <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) m_ticks[k] <= 0;
        end else begin
            m_held    <= m_match_now;
            m_press   <= m_match_now & ~m_held;
            m_release <= ~m_match_now & m_held;
            m_kc      <= keycode;
            m_tick    <= vsync & ~m_vs_prev;
            m_vs_prev <= vsync;
            if (m_tick) begin
                m_frame   <= m_pending | m_press | m_rep_now;
                m_pending <= '0;
            end else begin
                m_pending <= m_pending | m_press | m_rep_now;
            end
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (m_press[k] || !m_held[k] || !repeat_en) m_ticks[k] <= 0;
                else if (m_tick)                           m_ticks[k] <= m_ticks[k] + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk_25MHz);
        @(negedge clk_25MHz);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    function automatic logic [7:0] pick_code();
        int          r;
        logic [47:0] codes;
        codes = KEY_CODES;
        r = $urandom_range(0, 15);
        if (r < 6)  return codes[8*r +: 8];
        if (r < 11) return 8'h00;
        if (r == 11) return ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
        return 8'($urandom_range(2, 255));
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_al = 1'b0; vsync = 1'b1; keycode = 32'h0000_001A; repeat_en = 1'b0;
        repeat (3) @(negedge clk_25MHz);
        n_tests++; if (key_held !== 6'd0)    begin n_fail++; $display("FAIL reset_held got %b want 000000", key_held); end
        n_tests++; if (key_press !== 6'd0)   begin n_fail++; $display("FAIL reset_press got %b want 000000", key_press); end
        n_tests++; if (key_release !== 6'd0) begin n_fail++; $display("FAIL reset_release got %b want 000000", key_release); end
        n_tests++; if (key_repeat !== 6'd0)  begin n_fail++; $display("FAIL reset_repeat got %b want 000000", key_repeat); end
        n_tests++; if (key_frame !== 6'd0)   begin n_fail++; $display("FAIL reset_frame got %b want 000000", key_frame); end
        n_tests++; if (frame_tick !== 1'b0)  begin n_fail++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        reset_al = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            n_tests++;
            if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_no_tick cycle %0d got %b want 0", i, frame_tick); end
            n_tests++;
            if (key_press !== ((i == 2) ? 6'b000001 : 6'b000000)) begin
                n_fail++; $display("FAIL reset_fresh_press cycle %0d got %b", i, key_press);
            end
        end
        keycode = '0; vsync = 1'b0;
        idle(4);
    endtask

    task automatic test_press_release();
        keycode = 32'h0000_0028;
        cyc();
        n_tests++; if (key_press !== 6'd0) begin n_fail++; $display("FAIL pr_early got %b want 000000", key_press); end
        cyc();
        n_tests++; if (key_press !== 6'b010000) begin n_fail++; $display("FAIL pr_press got %b want 010000", key_press); end
        n_tests++; if (key_held !== 6'b010000)  begin n_fail++; $display("FAIL pr_held got %b want 010000", key_held); end
        cyc();
        n_tests++; if (key_press !== 6'd0)      begin n_fail++; $display("FAIL pr_one_cycle got %b want 000000", key_press); end
        n_tests++; if (key_held !== 6'b010000)  begin n_fail++; $display("FAIL pr_still_held got %b want 010000", key_held); end
        keycode = '0;
        cyc();
        n_tests++; if (key_release !== 6'd0) begin n_fail++; $display("FAIL pr_rel_early got %b want 000000", key_release); end
        cyc();
        n_tests++; if (key_release !== 6'b010000) begin n_fail++; $display("FAIL pr_release got %b want 010000", key_release); end
        n_tests++; if (key_held !== 6'd0)         begin n_fail++; $display("FAIL pr_unheld got %b want 000000", key_held); end
        cyc();
        n_tests++; if (key_release !== 6'd0) begin n_fail++; $display("FAIL pr_rel_one_cycle got %b want 000000", key_release); end
    endtask

    task automatic test_multi_slot();
        keycode = 32'h1A04_001A;
        idle(2);
        n_tests++; if (key_press !== 6'b000011) begin n_fail++; $display("FAIL ms_press got %b want 000011", key_press); end
        cyc();
        n_tests++; if (key_press !== 6'd0) begin n_fail++; $display("FAIL ms_single got %b want 000000", key_press); end
        keycode = 32'h0101_0101;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_tests++;
            if (key_held !== 6'b000011 || key_press !== 6'd0 || key_release !== 6'd0) begin
                n_fail++;
                $display("FAIL rollover_hold cycle %0d held %b press %b release %b want 000011/0/0",
                         i, key_held, key_press, key_release);
            end
        end
        keycode = '0;
        idle(4);
    endtask

    task automatic test_frame_snapshot();
        repeat_en = 1'b0; keycode = '0; vsync = 1'b0;
        idle(2);
        vsync = 1'b1; cyc(); vsync = 1'b0; idle(3);           // frame N begins
        keycode = 32'h0000_002C; idle(4);                     // press mid-frame N
        n_tests++; if (key_frame[5] !== 1'b0) begin n_fail++; $display("FAIL fs_before got %b want 0", key_frame[5]); end
        vsync = 1'b1; cyc();                                  // tick N+1
        n_tests++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL fs_tick got %b want 1", frame_tick); end
        vsync = 1'b0; cyc();
        n_tests++; if (key_frame[5] !== 1'b1) begin n_fail++; $display("FAIL fs_snapshot got %b want 1", key_frame[5]); end
        idle(3);
        n_tests++; if (key_frame[5] !== 1'b1) begin n_fail++; $display("FAIL fs_stable got %b want 1", key_frame[5]); end
        vsync = 1'b1; cyc(); vsync = 1'b0; cyc();             // tick N+2
        n_tests++; if (key_frame[5] !== 1'b0) begin n_fail++; $display("FAIL fs_cleared got %b want 0", key_frame[5]); end
        // press landing in the very cycle of a frame tick
        keycode = '0; idle(4);
        keycode = 32'h0000_002C; cyc();
        vsync = 1'b1; cyc();
        n_tests++; if (key_press[5] !== 1'b1 || frame_tick !== 1'b1) begin
            n_fail++; $display("FAIL fs_coincide press %b tick %b want 1/1", key_press[5], frame_tick);
        end
        vsync = 1'b0; cyc();
        n_tests++; if (key_frame[5] !== 1'b1) begin n_fail++; $display("FAIL fs_coincide_snap got %b want 1", key_frame[5]); end
        idle(3);
        vsync = 1'b1; cyc(); vsync = 1'b0; cyc();
        n_tests++; if (key_frame[5] !== 1'b0) begin n_fail++; $display("FAIL fs_coincide_not_pending got %b want 0", key_frame[5]); end
        keycode = '0; idle(4);
    endtask

    task automatic test_repeat();
        logic [5:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            repeat_en = 1'b1; keycode = '0; vsync = 1'b0; idle(4);
            keycode = 32'h0000_0700; idle(4);                 // key 3 pressed, before tick 1
            for (int i = 1; i <= 32; i++) begin
                vsync = 1'b1; cyc();
                if (pass == 0) want = (i >= 20 && (i - 20) % 4 == 0) ? 6'b001000 : 6'b000000;
                else           want = (i == 20) ? 6'b001000 : 6'b000000;
                n_tests++;
                if (frame_tick !== 1'b1 || key_repeat !== want) begin
                    n_fail++;
                    $display("FAIL repeat pass %0d tick %0d tick %b repeat %b want 1/%b",
                             pass, i, frame_tick, key_repeat, want);
                end
                vsync = 1'b0;
                if (pass == 1 && i == 22) repeat_en = 1'b0;
                if (pass == 1 && i == 26) repeat_en = 1'b1;
                idle(3);
            end
        end
        keycode = '0; repeat_en = 1'b0; idle(4);
    endtask

    task automatic test_reset_mid_hold();
        logic [5:0] want;
        repeat_en = 1'b1; keycode = '0; vsync = 1'b0; idle(4);
        keycode = 32'h0016_0000; idle(4);                     // key 2 pressed
        for (int i = 0; i < 10; i++) begin
            vsync = 1'b1; cyc(); vsync = 1'b0; idle(3);
        end
        cyc();
        #1 reset_al = 1'b0;
        #1;
        n_tests++;
        if ({key_held, key_press, key_release, key_repeat, key_frame, frame_tick} !== 31'd0) begin
            n_fail++;
            $display("FAIL mid_reset_clear held %b press %b rel %b rep %b frame %b tick %b want all 0",
                     key_held, key_press, key_release, key_repeat, key_frame, frame_tick);
        end
        @(negedge clk_25MHz); @(negedge clk_25MHz);
        reset_al = 1'b1;
        cyc();
        n_tests++; if (key_press !== 6'd0) begin n_fail++; $display("FAIL mid_reset_early got %b want 000000", key_press); end
        cyc();
        n_tests++; if (key_press !== 6'b000100) begin n_fail++; $display("FAIL mid_reset_press got %b want 000100", key_press); end
        idle(2);
        for (int i = 1; i <= 20; i++) begin
            vsync = 1'b1; cyc();
            want = (i == 20) ? 6'b000100 : 6'b000000;
            n_tests++;
            if (key_repeat !== want) begin
                n_fail++; $display("FAIL mid_reset_repeat tick %0d got %b want %b", i, key_repeat, want);
            end
            vsync = 1'b0; idle(3);
        end
        keycode = '0; repeat_en = 1'b0; idle(4);
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0)
                for (int s = 0; s < NUM_SLOTS; s++) keycode[8*s +: 8] = pick_code();
            if ($urandom_range(0, 63) == 0) repeat_en = ~repeat_en;
            vsync = ($urandom_range(0, 7) == 0);
            cyc();
            n_tests++; if (key_held !== m_held)       begin n_fail++; $display("FAIL rnd_held cyc %0d got %b want %b", c, key_held, m_held); end
            n_tests++; if (key_press !== m_press)     begin n_fail++; $display("FAIL rnd_press cyc %0d got %b want %b", c, key_press, m_press); end
            n_tests++; if (key_release !== m_release) begin n_fail++; $display("FAIL rnd_release cyc %0d got %b want %b", c, key_release, m_release); end
            n_tests++; if (key_repeat !== m_rep_now)  begin n_fail++; $display("FAIL rnd_repeat cyc %0d got %b want %b", c, key_repeat, m_rep_now); end
            n_tests++; if (key_frame !== m_frame)     begin n_fail++; $display("FAIL rnd_frame cyc %0d got %b want %b", c, key_frame, m_frame); end
            n_tests++; if (frame_tick !== m_tick)     begin n_fail++; $display("FAIL rnd_tick cyc %0d got %b want %b", c, frame_tick, m_tick); end
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_multi_slot();
        test_frame_snapshot();
        test_repeat();
        test_reset_mid_hold();
        repeat_en = 1'b1;
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
